// File: rtl/cpu.sv
// Single-cycle Hack CPU: A/D registers, Hack ALU, and program counter.
// One instruction per clock; memory interface is combinational except addressM/pc.

module register #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

module cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] inM,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [14:0] addressM,
  output logic [14:0] pc
);
  logic [15:0] w_a;
  logic [15:0] w_d;
  logic [15:0] w_x;
  logic [15:0] w_y;
  logic [15:0] w_f;
  logic [15:0] w_alu;
  logic [15:0] w_a_in;
  logic        w_is_c;
  logic        w_zr;
  logic        w_ng;
  logic        w_jump;
  logic        w_load_a;
  logic        w_load_d;
  logic        w_unused_bits;
  logic [14:0] r_pc;

  assign w_is_c = instruction[15];

  // ALU operands always see the pre-edge A and D.
  always_comb begin
    w_x = instruction[11] ? 16'd0 : w_d;
    if (instruction[10]) w_x = ~w_x;
    w_y = instruction[12] ? inM : w_a;
    if (instruction[9]) w_y = 16'd0;
    if (instruction[8]) w_y = ~w_y;
    w_f   = instruction[7] ? (w_x + w_y) : (w_x & w_y);
    w_alu = instruction[6] ? ~w_f : w_f;
  end

  assign w_zr   = (w_alu == 16'd0);
  assign w_ng   = w_alu[15];
  assign w_jump = w_is_c & ((instruction[2] & w_ng) |
                            (instruction[1] & w_zr) |
                            (instruction[0] & ~w_ng & ~w_zr));

  assign w_load_a = ~w_is_c | instruction[5];
  assign w_load_d = w_is_c & instruction[4];
  assign w_a_in   = w_is_c ? w_alu : instruction;

  register #(.W(16)) u_a_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load_a),
    .i_d     (w_a_in),
    .o_q     (w_a)
  );

  register #(.W(16)) u_d_reg (
    .i_clk   (clk),
    .i_reset (reset),
    .i_load  (w_load_d),
    .i_d     (w_alu),
    .o_q     (w_d)
  );

  // Reset wins over a taken jump; increment wraps naturally at 15 bits.
  always_ff @(posedge clk) begin
    if (reset)       r_pc <= 15'd0;
    else if (w_jump) r_pc <= w_a[14:0];
    else             r_pc <= r_pc + 15'd1;
  end

  assign outM     = w_alu;
  assign writeM   = w_is_c & instruction[3] & ~reset;
  assign addressM = w_a[14:0];
  assign pc       = r_pc;

  // Instruction bits 14:13 and A[15] have no function in this core.
  assign w_unused_bits = ^{instruction[14:13], w_a[15]};
endmodule

// File: tb/tb_cpu.sv
// Bench for the Hack CPU: directed vector table, then random instructions
// checked against a behavioural model of the Hack machine.

module tb_cpu;
  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  int checks;
  int failures;

  cpu dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic [15:0] in_m;
    logic        exp_wm;
    logic [15:0] exp_out;
    logic [14:0] exp_pc;
    logic [14:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model state
  logic [15:0] m_a;
  logic [15:0] m_d;
  logic [14:0] m_pc;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [15:0] i, input logic [15:0] m,
                              input logic wm, input logic [15:0] o,
                              input logic [14:0] p, input logic [14:0] a);
    vec_t v;
    v.rst = r; v.instr = i; v.in_m = m; v.exp_wm = wm; v.exp_out = o;
    v.exp_pc = p; v.exp_addr = a;
    return v;
  endfunction

  // Hack ALU written as the plain rules of the machine.
  function automatic logic [15:0] hack_alu(input logic [15:0] i, input logic [15:0] dv,
                                           input logic [15:0] av, input logic [15:0] mv);
    logic [15:0] x, y, o;
    x = dv;
    y = i[12] ? mv : av;
    if (i[11]) x = 0;
    if (i[10]) x = ~x;
    if (i[9])  y = 0;
    if (i[8])  y = ~y;
    if (i[7]) o = 16'((int'(x) + int'(y)) % 65536);
    else      o = x & y;
    if (i[6]) o = ~o;
    return o;
  endfunction

  // Applies inputs, checks combinational outputs, clocks, checks registered state.
  task automatic step(input vec_t v, input string tag);
    reset = v.rst; instruction = v.instr; inM = v.in_m;
    #1;
    check({tag, " writeM"}, {15'd0, writeM}, {15'd0, v.exp_wm});
    if (v.exp_wm) check({tag, " outM"}, outM, v.exp_out);
    @(posedge clk); #1;
    check({tag, " pc"}, {1'b0, pc}, {1'b0, v.exp_pc});
    check({tag, " addressM"}, {1'b0, addressM}, {1'b0, v.exp_addr});
  endtask

  task automatic model_step(input logic r, input logic [15:0] i, input logic [15:0] mv,
                            output logic exp_wm, output logic [15:0] exp_out);
    logic [15:0] o;
    int so;
    logic take;
    o = hack_alu(i, m_d, m_a, mv);
    exp_out = o;
    exp_wm = !r && i[15] && i[3];
    so = int'($signed(o));
    take = i[15] && ((i[2] && so < 0) || (i[1] && so == 0) || (i[0] && so > 0));
    if (r) begin
      m_a = 0; m_d = 0; m_pc = 0;
    end else begin
      m_pc = take ? m_a[14:0] : 15'((int'(m_pc) + 1) % 32768);
      if (!i[15]) m_a = i;
      else begin
        if (i[4]) m_d = o;
        if (i[5]) m_a = o;
      end
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; instruction = 16'h0000; inM = 16'h0000;
    @(posedge clk); #1;

    // rst, instr, inM, writeM, outM, pc after, addressM after
    vecs.push_back(mk(1, 16'hEA87, 16'h0000, 0, 16'h0000, 15'd0,     15'd0));
    vecs.push_back(mk(0, 16'hE308, 16'h0000, 1, 16'h0000, 15'd1,     15'd0));
    vecs.push_back(mk(0, 16'h3039, 16'h0000, 0, 16'h0000, 15'd2,     15'd12345));
    vecs.push_back(mk(0, 16'hEC10, 16'h0000, 0, 16'h0000, 15'd3,     15'd12345));
    vecs.push_back(mk(0, 16'hE308, 16'h0000, 1, 16'd12345, 15'd4,    15'd12345));
    vecs.push_back(mk(0, 16'hFDD0, 16'h8285, 0, 16'h0000, 15'd5,     15'd12345));
    vecs.push_back(mk(0, 16'hE308, 16'h0000, 1, 16'h8286, 15'd6,     15'd12345));
    vecs.push_back(mk(0, 16'h3039, 16'h0000, 0, 16'h0000, 15'd7,     15'd12345));
    vecs.push_back(mk(0, 16'hEC10, 16'h0000, 0, 16'h0000, 15'd8,     15'd12345));
    vecs.push_back(mk(0, 16'h0064, 16'h0000, 0, 16'h0000, 15'd9,     15'd100));
    vecs.push_back(mk(0, 16'hE301, 16'h0000, 0, 16'h0000, 15'd100,   15'd100));
    vecs.push_back(mk(0, 16'hE302, 16'h0000, 0, 16'h0000, 15'd101,   15'd100));
    vecs.push_back(mk(0, 16'hEA90, 16'h0000, 0, 16'h0000, 15'd102,   15'd100));
    vecs.push_back(mk(0, 16'hE302, 16'h0000, 0, 16'h0000, 15'd100,   15'd100));
    vecs.push_back(mk(0, 16'h0007, 16'h0000, 0, 16'h0000, 15'd101,   15'd7));
    vecs.push_back(mk(0, 16'hEC10, 16'h0000, 0, 16'h0000, 15'd102,   15'd7));
    vecs.push_back(mk(0, 16'h0064, 16'h0000, 0, 16'h0000, 15'd103,   15'd100));
    vecs.push_back(mk(0, 16'hE327, 16'h0000, 0, 16'h0000, 15'd100,   15'd7));
    vecs.push_back(mk(0, 16'h7FFF, 16'h0000, 0, 16'h0000, 15'd101,   15'd32767));
    vecs.push_back(mk(0, 16'hEA87, 16'h0000, 0, 16'h0000, 15'd32767, 15'd32767));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 15'd0,     15'd0));
    vecs.push_back(mk(0, 16'h0064, 16'h0000, 0, 16'h0000, 15'd1,     15'd100));
    vecs.push_back(mk(1, 16'hEA8F, 16'h0000, 0, 16'h0000, 15'd0,     15'd0));
    vecs.push_back(mk(0, 16'hE308, 16'h0000, 1, 16'h0000, 15'd1,     15'd0));

    foreach (vecs[k]) step(vecs[k], $sformatf("vec%0d", k));

    // Multi-cycle: mid-run reset while a taken jump is decoded, then restart from 0.
    step(mk(0, 16'h1234, 16'h0000, 0, 16'h0000, 15'd2, 15'h1234), "seq_ld");
    step(mk(1, 16'hEA87, 16'h0000, 0, 16'h0000, 15'd0, 15'd0),    "seq_rst_jmp");
    step(mk(0, 16'h0005, 16'h0000, 0, 16'h0000, 15'd1, 15'd5),    "seq_after_rst");

    // Random instructions against the model, starting from a clean reset.
    m_a = 0; m_d = 0; m_pc = 0;
    step(mk(1, 16'h0000, 16'h0000, 0, 16'h0000, 15'd0, 15'd0), "rnd_rst");
    for (int n = 0; n < 400; n++) begin
      vec_t v;
      logic ewm;
      logic [15:0] eo;
      v.rst   = ($urandom_range(0, 31) == 0);
      v.instr = 16'($urandom());
      if ($urandom_range(0, 2) == 0) v.instr[15] = 1'b0;
      v.in_m  = 16'($urandom());
      model_step(v.rst, v.instr, v.in_m, ewm, eo);
      v.exp_wm = ewm; v.exp_out = eo; v.exp_pc = m_pc; v.exp_addr = m_a[14:0];
      step(v, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu.md
# cpu

Single-cycle Hack CPU core: decodes one 16-bit Hack instruction per clock, holds the A and D 16-bit registers (instances of the team's `register` block), computes the Hack ALU function, and drives the program counter. Sits directly downstream of `register` and between instruction ROM (fed by `pc`) and data memory (via `inM`/`outM`/`writeM`/`addressM`).

## Interface
- No parameters (Hack word width fixed at 16, address width 15).
- `clk` input 1: rising-edge clock for all state.
- `reset` input 1: synchronous, active-high; sampled on `clk` rising edge.
- `instruction` input 16: current instruction from ROM at address `pc`.
- `inM` input 16: data memory read value at `addressM`, combinational, same cycle.
- `outM` output 16: ALU result; combinational; meaningful when `writeM`=1.
- `writeM` output 1: data memory write enable, combinational.
- `addressM` output 15: A[14:0] (registered value).
- `pc` output 15: program counter (registered value).

## Operation
- State: A (16b), D (16b), PC (15b). Reset value of A, D, PC = 0.
- A-instruction (`instruction[15]`=0): A <= `instruction`; D unchanged; PC <= PC+1; `writeM`=0.
- C-instruction (`instruction[15]`=1), fields: bits 14:13 ignored; a=bit12; c1..c6=bits11:6 (zx,nx,zy,ny,f,no); d1..d3=bits5:3 (A,D,M); j1..j3=bits2:0 (lt,eq,gt).
- ALU inputs: x = D; y = a ? `inM` : A. zx: x=0; nx: x=~x; zy: y=0; ny: y=~y; f: out = x+y (mod 2^16) else x&y; no: out=~out. zr = (out==0); ng = out[15].
- d1: A <= out. d2: D <= out. d3: `writeM`=1, `outM`=out written to `addressM`.
- Jump taken iff C-instruction and ((j1&ng)|(j2&zr)|(j3&~ng&~zr)). Taken: PC <= A[14:0]; else PC <= PC+1.
- All reads use pre-edge values: jump target, `addressM`, and ALU operands see old A/D even when the same instruction writes A/D.
- PC priority: reset > jump > increment. Increment wraps 0x7FFF -> 0x0000.
- `reset`=1: on edge A,D,PC <= 0; `writeM` forced 0 combinationally while `reset`=1 (regardless of instruction).
- A-instruction with bit15=0 stores 16 bits; A[15]=0 by construction; C-instruction may set A[15]=1; `addressM` drops it.

## Timing
- Single cycle per instruction, no stalls, no handshake.
- `outM`, `writeM` combinational from `instruction`, `inM`, A, D, `reset`; settle before next edge.
- A, D, PC update on the same rising edge; visible on `addressM`/`pc` immediately after.
- Memory write occurs at the edge ending the cycle `writeM`=1, using the pre-edge `addressM`.
- Reset latency: 1 edge; first fetch after deassertion is address 0.

## Test plan
- Reset: hold `reset`=1 one edge with any instruction (e.g. 0xEA87) -> `pc`=0, `addressM`=0, `writeM`=0 during reset; D=0 (check via 0xE308 next: `outM`=0).
- Load/store: 0x3039 -> `addressM`=12345, `pc`=1; 0xEC10 (D=A) -> `pc`=2; 0xE308 (M=D) -> `writeM`=1, `outM`=12345, `addressM`=12345.
- M as operand: `addressM`=12345, `inM`=-32123, 0xFDD0 (D=M+1) -> then 0xE308 gives `outM`=-32122; 0xE308 with `writeM` sampled only that cycle.
- Conditional jumps: D=12345, @100 (0x0064), 0xE301 (D;JGT) -> `pc`=100; repeat with 0xE302 (D;JEQ) -> `pc`=old+1; D=0 with 0xE302 -> taken.
- Simultaneous A write + jump: A=100, D=7, 0xE327 (A=D;JMP) -> `pc`=100, `addressM`=7.
- Wrap and mid-run reset: 0x7FFF then 0xEA87 (0;JMP) -> `pc`=32767; next 0x0000 -> `pc`=0; `reset`=1 during a taken 0;JMP -> `pc`=0 not A.
